// File: rtl/piso_shift_reg_if.sv
// piso_shift_reg_if: load handshake and serial output bundle for piso_shift_reg
interface piso_shift_reg_if #(parameter int WIDTH = 4);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] pi;
  logic             so;
  logic             so_valid;
  logic             frame_done;
  logic             busy;
  modport master (output load_valid, pi, input load_ready, so, so_valid, frame_done, busy);
  modport slave  (input load_valid, pi, output load_ready, so, so_valid, frame_done, busy);
endinterface

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out shifter, LSB first, gapless back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             clear_n,
  piso_shift_reg_if.slave bus
);
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last, accept;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif
  assign last   = (state_q == SHIFT) && (cnt_q == LAST);
  assign accept = bus.load_valid && bus.load_ready;
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  always_comb begin
    state_d = (state_q == IDLE || last) ? (accept ? SHIFT : IDLE) : SHIFT;
  end
  always_comb begin
    sreg_d = accept ? bus.pi : (state_q == SHIFT) ? sreg_q >> 1 : sreg_q;
    cnt_d  = (accept || last) ? '0 : (state_q == SHIFT) ? cnt_q + CW'(1) : cnt_q;
`ifdef PISO_PARITY_EN
    par_d  = accept ? ^bus.pi : par_q;
`endif
  end
  // Outputs decode registered state only; clear_n gates load_ready directly.
  always_comb begin
    bus.load_ready = clear_n && (state_q == IDLE || last);
    bus.so_valid   = state_q == SHIFT;
    bus.busy       = state_q == SHIFT;
    bus.frame_done = last;
`ifdef PISO_PARITY_EN
    bus.so         = (state_q == SHIFT) && ((cnt_q == CW'(WIDTH)) ? par_q : sreg_q[0]);
`else
    bus.so         = (state_q == SHIFT) && sreg_q[0];
`endif
  end
endmodule

// File: tb/tb_piso_shift_reg.sv
// tb_piso_shift_reg: table-driven and directed checks for piso_shift_reg (WIDTH=4 and WIDTH=8)
module tb_piso_shift_reg;
`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  typedef struct {
    logic       lv;
    logic [3:0] pi;
    logic       so, v, fd, rdy;
  } vec_t;
  logic clk = 0;
  logic clear_n = 0;
  int checks = 0;
  int errors = 0;
  vec_t vq[$];
  piso_shift_reg_if #(.WIDTH(4)) b4 ();
  piso_shift_reg_if #(.WIDTH(8)) b8 ();
  piso_shift_reg #(.WIDTH(4)) dut4 (.clk(clk), .clear_n(clear_n), .bus(b4));
  piso_shift_reg #(.WIDTH(8)) dut8 (.clk(clk), .clear_n(clear_n), .bus(b8));
  always #5 clk = ~clk;
  function automatic void add(logic lv, logic [3:0] pi, logic so, logic v, logic fd, logic rdy);
    vec_t r;
    r.lv = lv; r.pi = pi; r.so = so; r.v = v; r.fd = fd; r.rdy = rdy;
    vq.push_back(r);
  endfunction
  task automatic chk(string name, logic [4:0] act, logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got so/v/fd/rdy/busy=%b expected %b", name, act, exp);
    end
  endtask
  function automatic logic [4:0] o4();
    return {b4.so, b4.so_valid, b4.frame_done, b4.load_ready, b4.busy};
  endfunction
  function automatic logic [4:0] o8();
    return {b8.so, b8.so_valid, b8.frame_done, b8.load_ready, b8.busy};
  endfunction
  initial begin
    logic [3:0] w4;
    logic [7:0] w8;
    logic       e;
    b4.load_valid = 0; b4.pi = '0;
    b8.load_valid = 0; b8.pi = '0;
`ifdef PISO_PARITY_EN
    add(1, 4'b0111, 0,0,0,1);
    add(0, 4'b0000, 1,1,0,0); add(0, 4'b0000, 1,1,0,0);
    add(0, 4'b0000, 1,1,0,0); add(0, 4'b0000, 0,1,0,0);
    add(1, 4'b0011, 1,1,1,1);
    add(0, 4'b0000, 1,1,0,0); add(0, 4'b0000, 1,1,0,0);
    add(0, 4'b0000, 0,1,0,0); add(0, 4'b0000, 0,1,0,0);
    add(0, 4'b0000, 0,1,1,1);
    add(0, 4'b0000, 0,0,0,1);
`else
    add(1, 4'b1011, 0,0,0,1);
    add(0, 4'b0000, 1,1,0,0); add(0, 4'b0000, 1,1,0,0);
    add(0, 4'b0000, 0,1,0,0); add(0, 4'b0000, 1,1,1,1);
    add(0, 4'b0000, 0,0,0,1);
    add(1, 4'b1011, 0,0,0,1);
    add(1, 4'b1011, 1,1,0,0); add(1, 4'b1011, 1,1,0,0);
    add(1, 4'b1011, 0,1,0,0); add(1, 4'b0100, 1,1,1,1);
    add(0, 4'b0000, 0,1,0,0); add(0, 4'b0000, 0,1,0,0);
    add(0, 4'b0000, 1,1,0,0); add(0, 4'b0000, 0,1,1,1);
    add(0, 4'b0000, 0,0,0,1);
    add(1, 4'b0110, 0,0,0,1);
    add(1, 4'b1111, 0,1,0,0); add(1, 4'b1111, 1,1,0,0);
    add(1, 4'b1111, 1,1,0,0); add(1, 4'b1111, 0,1,1,1);
    add(0, 4'b0000, 1,1,0,0); add(0, 4'b0000, 1,1,0,0);
    add(0, 4'b0000, 1,1,0,0); add(0, 4'b0000, 1,1,1,1);
    add(0, 4'b0000, 0,0,0,1);
`endif
    #12;
    chk("reset4", o4(), 5'b00000);
    chk("reset8", o8(), 5'b00000);
    @(negedge clk);
    clear_n = 1;
    #1 chk("idle_after_release", o4(), 5'b00010);
    foreach (vq[i]) begin
      @(negedge clk);
      b4.load_valid = vq[i].lv;
      b4.pi = vq[i].pi;
      #1 chk($sformatf("row%0d", i), o4(), {vq[i].so, vq[i].v, vq[i].fd, vq[i].rdy, vq[i].v});
    end
    // Reset in the middle of a frame: outputs drop without a clock edge.
    @(negedge clk);
    b4.load_valid = 1; b4.pi = 4'b1101;
    w4 = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b4.load_valid = 0;
      #1 chk($sformatf("abort_bit%0d", i), o4(), {w4[i], 4'b1001});
    end
    #2 clear_n = 0;
    #1 chk("abort_async", o4(), 5'b00000);
    @(negedge clk);
    #1 chk("abort_held", o4(), 5'b00000);
    @(negedge clk);
    clear_n = 1;
    #1 chk("abort_released", o4(), 5'b00010);
    b4.load_valid = 1; b4.pi = 4'b0001;
    w4 = 4'b0001;
    for (int i = 0; i < 4 + PAR; i++) begin
      @(negedge clk);
      b4.load_valid = 0;
      e = (i < 4) ? w4[i] : ^w4;
      #1 chk($sformatf("after_abort_bit%0d", i), o4(),
             {e, 1'b1, i == 3 + PAR, i == 3 + PAR, 1'b1});
    end
    @(negedge clk);
    #1 chk("after_abort_idle", o4(), 5'b00010);
    // Wide word: counter must run the full frame without wrapping.
    b8.load_valid = 1; b8.pi = 8'hA5;
    w8 = 8'hA5;
    #1 chk("w8_idle", o8(), 5'b00010);
    for (int i = 0; i < 8 + PAR; i++) begin
      @(negedge clk);
      b8.load_valid = 0;
      e = (i < 8) ? w8[i] : ^w8;
      #1 chk($sformatf("w8_bit%0d", i), o8(),
             {e, 1'b1, i == 7 + PAR, i == 7 + PAR, 1'b1});
    end
    @(negedge clk);
    #1 chk("w8_done_idle", o8(), 5'b00010);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
Parallel-in serial-out shift register, the transmit-side counterpart of the serial-in parallel-out capture register. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock, LSB first (right shift). It flags each valid serial bit and the end of each frame. Back-to-back loads produce a continuous bit stream with no idle cycle between frames.

Parameters:
WIDTH, 4, data word width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock.
clear_n  input  1  asynchronous active-low reset.
load_valid  input  1  parallel word is presented on pi.
load_ready  output  1  block will capture pi at the next rising edge if load_valid is high.
pi  input  WIDTH  parallel input word.
so  output  1  serial output bit.
so_valid  output  1  so carries a frame bit this cycle.
frame_done  output  1  high during the last bit of a frame.
busy  output  1  a frame is in progress (equals so_valid).

Behaviour:
- Reset (clear_n low, asynchronous): state=IDLE, shift register=0, bit counter=0, so=0, so_valid=0, frame_done=0, busy=0.
- load_ready is forced 0 while clear_n is low.
- FSM states:
  - IDLE: so=0, so_valid=0, load_ready=1.
  - SHIFT: so=sreg[0], so_valid=1, busy=1.
- Accept: a load is accepted when load_valid && load_ready at a rising edge. On accept: sreg<=pi, cnt<=0, state<=SHIFT.
- Latency: a word accepted at edge k drives bit 0 on so from edge k through edge k+1. Bit i is driven in the i-th cycle after edge k.
- In SHIFT, each edge: sreg<=sreg>>1 (zero fill), cnt<=cnt+1.
- Last bit (cnt==FRAME_LEN-1):
  - frame_done=1 and load_ready=1, both combinational from state and cnt.
  - If a load is accepted at the closing edge, the FSM reloads and stays in SHIFT, so the stream is gapless.
  - Otherwise it goes to IDLE.
- FRAME_LEN=WIDTH, or WIDTH+1 when the optional parity feature is compiled in.
- In SHIFT with cnt < FRAME_LEN-1, load_ready=0. load_valid is ignored and pi changes have no effect on the frame in flight.
- cnt width is $clog2(WIDTH+1). cnt never exceeds FRAME_LEN-1.
- Reset mid-frame aborts immediately. The partial frame is lost with no frame_done. The first valid edge after release starts from IDLE.
- so and so_valid are driven from registered state only, with no combinational path from pi or load_valid. load_ready and frame_done are decoded from registered state.

Optional Feature:
PISO_PARITY_EN:
- Defined:
  - On accept, even parity of pi (XOR of all bits) is latched.
  - After the WIDTH data bits, one extra cycle drives so=parity with so_valid=1.
  - frame_done and load_ready move to that parity cycle.
  - FRAME_LEN=WIDTH+1.
- Undefined: no parity logic, FRAME_LEN=WIDTH, and frame_done occurs on data bit WIDTH-1.

Test Plan:
1. Reset, then load 4'b1011 for one cycle -> so=1,1,0,1 on four consecutive cycles; so_valid high exactly 4 cycles; frame_done only on the 4th; then IDLE with so=0 and load_ready=1.
2. Hold load_valid with 4'b1011, then switch pi to 4'b0100 when frame_done is high -> 8 gapless valid bits 1,1,0,1,0,0,1,0; frame_done on cycles 4 and 8.
3. After loading 4'b0110, drive load_valid=1 with pi=4'b1111 during bits 0-2 -> load_ready=0; output stays 0,1,1,0; second word is captured only at the frame_done edge.
4. Load 4'b1101 and pull clear_n low during bit 2 -> so, so_valid and busy drop to 0 without waiting for a clock; no frame_done; after release, load 4'b0001 -> 1,0,0,0.
5. With PISO_PARITY_EN defined, load 4'b0111 -> so=1,1,1,0 then parity bit 1; 5 valid cycles; frame_done on the 5th. Then load 4'b0011 -> 1,1,0,0,0.
6. With WIDTH=8, load 8'hA5 -> so=1,0,1,0,0,1,0,1; frame_done on the 8th bit; counter does not wrap before frame end.
